// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the extended multicycle MIPS controller: states, opcodes,
// datapath mux selects and the decoded control word.
package mips_ctrl_pkg;

   typedef enum logic [4:0] {
      S_FETCH    = 5'd0,
      S_DECODE   = 5'd1,
      S_MEMADR   = 5'd2,
      S_MEMRD    = 5'd3,
      S_MEMWB    = 5'd4,
      S_MEMWR    = 5'd5,
      S_RTYPE_EX = 5'd6,
      S_RTYPE_WB = 5'd7,
      S_BEQ      = 5'd8,
      S_BNE      = 5'd9,
      S_ADDI_EX  = 5'd10,
      S_ANDI_EX  = 5'd11,
      S_ORI_EX   = 5'd12,
      S_SLTI_EX  = 5'd13,
      S_IMM_WB   = 5'd14,
      S_JUMP     = 5'd15,
      S_JAL      = 5'd16
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   typedef enum logic [2:0] {
      ALU_ADD   = 3'd0,
      ALU_SUB   = 3'd1,
      ALU_FUNCT = 3'd2,
      ALU_AND   = 3'd3,
      ALU_OR    = 3'd4,
      ALU_SLT   = 3'd5
   } alu_op_t;

   localparam logic [1:0] RDST_RT   = 2'b00;
   localparam logic [1:0] RDST_RD   = 2'b01;
   localparam logic [1:0] RDST_RA   = 2'b10;

   localparam logic [1:0] M2R_ALU   = 2'b00;
   localparam logic [1:0] M2R_MDR   = 2'b01;
   localparam logic [1:0] M2R_PC    = 2'b10;

   localparam logic [1:0] SRCB_RT   = 2'b00;
   localparam logic [1:0] SRCB_4    = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_IMM4 = 2'b11;

   localparam logic [1:0] PCS_ALU    = 2'b00;
   localparam logic [1:0] PCS_ALUOUT = 2'b01;
   localparam logic [1:0] PCS_JUMP   = 2'b10;

   // wait_rdy marks states whose write strobes must be qualified by mem_ready
   typedef struct packed {
      logic       pc_write;
      logic       branch;
      logic       nef;
      logic       iord;
      logic       mem_req;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       ext_zero;
      logic [1:0] pc_src;
      alu_op_t    alu_op;
      logic       wait_rdy;
   } ctrl_t;

endpackage

// File: rtl/mctrl_out_decode.sv
// Pure combinational state -> control word decode; zero latency, no handshake.
// Unreachable encodings decode to an all-zero word.
module mctrl_out_decode
   import mips_ctrl_pkg::*;
(
   input  state_t i_state,
   output ctrl_t  o_ctl
);

   always_comb begin
      o_ctl = '0;
      case (i_state)
         S_FETCH: begin
            o_ctl.mem_req   = 1'b1;
            o_ctl.alu_src_b = SRCB_4;
            o_ctl.pc_write  = 1'b1;
            o_ctl.ir_write  = 1'b1;
            o_ctl.wait_rdy  = 1'b1;
         end
         S_DECODE: o_ctl.alu_src_b = SRCB_IMM4;
         S_MEMADR: begin
            o_ctl.alu_src_a = 1'b1;
            o_ctl.alu_src_b = SRCB_IMM;
         end
         S_MEMRD: begin
            o_ctl.mem_req = 1'b1;
            o_ctl.iord    = 1'b1;
         end
         S_MEMWB: begin
            o_ctl.reg_write  = 1'b1;
            o_ctl.reg_dst    = RDST_RT;
            o_ctl.mem_to_reg = M2R_MDR;
         end
         S_MEMWR: begin
            o_ctl.mem_req   = 1'b1;
            o_ctl.iord      = 1'b1;
            o_ctl.mem_write = 1'b1;
            o_ctl.wait_rdy  = 1'b1;
         end
         S_RTYPE_EX: begin
            o_ctl.alu_src_a = 1'b1;
            o_ctl.alu_src_b = SRCB_RT;
            o_ctl.alu_op    = ALU_FUNCT;
         end
         S_RTYPE_WB: begin
            o_ctl.reg_write  = 1'b1;
            o_ctl.reg_dst    = RDST_RD;
            o_ctl.mem_to_reg = M2R_ALU;
         end
         S_BEQ, S_BNE: begin
            o_ctl.alu_src_a = 1'b1;
            o_ctl.alu_src_b = SRCB_RT;
            o_ctl.alu_op    = ALU_SUB;
            o_ctl.branch    = 1'b1;
            o_ctl.pc_src    = PCS_ALUOUT;
            o_ctl.nef       = (i_state == S_BNE);
         end
         S_ADDI_EX, S_ANDI_EX, S_ORI_EX, S_SLTI_EX: begin
            o_ctl.alu_src_a = 1'b1;
            o_ctl.alu_src_b = SRCB_IMM;
            o_ctl.ext_zero  = (i_state == S_ANDI_EX) || (i_state == S_ORI_EX);
            case (i_state)
               S_ANDI_EX: o_ctl.alu_op = ALU_AND;
               S_ORI_EX:  o_ctl.alu_op = ALU_OR;
               S_SLTI_EX: o_ctl.alu_op = ALU_SLT;
               default:   o_ctl.alu_op = ALU_ADD;
            endcase
         end
         S_IMM_WB: begin
            o_ctl.reg_write  = 1'b1;
            o_ctl.reg_dst    = RDST_RT;
            o_ctl.mem_to_reg = M2R_ALU;
         end
         S_JUMP: begin
            o_ctl.pc_write = 1'b1;
            o_ctl.pc_src   = PCS_JUMP;
         end
         S_JAL: begin
            o_ctl.pc_write   = 1'b1;
            o_ctl.pc_src     = PCS_JUMP;
            o_ctl.reg_write  = 1'b1;
            o_ctl.reg_dst    = RDST_RA;
            o_ctl.mem_to_reg = M2R_PC;
         end
         default: o_ctl = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_control_ext.sv
// Multicycle MIPS main control FSM with memory wait handshake and illegal-op pulse.
// Outputs are Moore decodes of the state; FETCH/MEMRD/MEMWR hold until mem_ready.
module multicycle_control_ext
   import mips_ctrl_pkg::*;
#(
   parameter int MEM_WAIT = 1,
   parameter int ALUOP_W  = 3,
   parameter int STATE_W  = 5
)(
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         op,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               branch,
   output logic               nef,
   output logic               iord,
   output logic               mem_req,
   output logic               mem_write,
   output logic               ir_write,
   output logic               reg_write,
   output logic [1:0]         reg_dst,
   output logic [1:0]         mem_to_reg,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic               ext_zero,
   output logic [1:0]         pc_src,
   output logic [ALUOP_W-1:0] alu_op,
   output logic               illegal_op,
   output logic [STATE_W-1:0] state_dbg
);

   state_t r_state;
   logic   r_illegal;
   ctrl_t  w_ctl;
   logic   w_ready;
   logic   w_go;

   assign w_ready = (MEM_WAIT != 0) ? mem_ready : 1'b1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_FETCH;
         r_illegal <= 1'b0;
      end else begin
         r_illegal <= 1'b0;
         case (r_state)
            S_FETCH:  if (w_ready) r_state <= S_DECODE;
            S_DECODE: begin
               case (op)
                  OP_RTYPE:     r_state <= S_RTYPE_EX;
                  OP_LW, OP_SW: r_state <= S_MEMADR;
                  OP_BEQ:       r_state <= S_BEQ;
                  OP_BNE:       r_state <= S_BNE;
                  OP_ADDI:      r_state <= S_ADDI_EX;
                  OP_ANDI:      r_state <= S_ANDI_EX;
                  OP_ORI:       r_state <= S_ORI_EX;
                  OP_SLTI:      r_state <= S_SLTI_EX;
                  OP_J:         r_state <= S_JUMP;
                  OP_JAL:       r_state <= S_JAL;
                  default: begin
                     r_state   <= S_FETCH;
                     r_illegal <= 1'b1;
                  end
               endcase
            end
            S_MEMADR:   r_state <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    if (w_ready) r_state <= S_MEMWB;
            S_MEMWR:    if (w_ready) r_state <= S_FETCH;
            S_RTYPE_EX: r_state <= S_RTYPE_WB;
            S_ADDI_EX, S_ANDI_EX, S_ORI_EX, S_SLTI_EX:
                        r_state <= S_IMM_WB;
            default:    r_state <= S_FETCH;
         endcase
      end
   end

   mctrl_out_decode u_dec (
      .i_state (r_state),
      .o_ctl   (w_ctl)
   );

   // Write strobes are qualified by mem_ready where the access may stall, and
   // forced low while reset is held so no partial write escapes.
   assign w_go       = ~w_ctl.wait_rdy | w_ready;
   assign pc_write   = reset & w_ctl.pc_write  & w_go;
   assign ir_write   = reset & w_ctl.ir_write  & w_go;
   assign mem_write  = reset & w_ctl.mem_write & w_go;
   assign reg_write  = reset & w_ctl.reg_write;
   assign branch     = reset & w_ctl.branch;
   assign illegal_op = reset & r_illegal;

   assign nef        = w_ctl.nef;
   assign iord       = w_ctl.iord;
   assign mem_req    = w_ctl.mem_req;
   assign reg_dst    = w_ctl.reg_dst;
   assign mem_to_reg = w_ctl.mem_to_reg;
   assign alu_src_a  = w_ctl.alu_src_a;
   assign alu_src_b  = w_ctl.alu_src_b;
   assign ext_zero   = w_ctl.ext_zero;
   assign pc_src     = w_ctl.pc_src;
   assign alu_op     = ALUOP_W'(w_ctl.alu_op);
   assign state_dbg  = STATE_W'(r_state);

endmodule

// File: tb/tb_multicycle_control_ext.sv
// Bench for multicycle_control_ext: instruction-path model checked every cycle,
// plus literal state sequences and control values per instruction class.
module tb_multicycle_control_ext;

   typedef struct packed {
      logic       pc_write;
      logic       branch;
      logic       nef;
      logic       iord;
      logic       mem_req;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       ext_zero;
      logic [1:0] pc_src;
      logic [2:0] alu_op;
      logic       illegal_op;
      logic [4:0] state;
   } obs_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [5:0] op = 6'h00;
   logic       mem_ready = 1'b0;
   logic       pc_write, branch, nef, iord, mem_req, mem_write, ir_write, reg_write;
   logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_src;
   logic       alu_src_a, ext_zero, illegal_op;
   logic [2:0] alu_op;
   logic [4:0] state_dbg;

   int checks = 0;
   int errors = 0;

   obs_t trace[$];
   int   path[$];
   int   m_state = 0;
   bit   m_ill = 1'b0;

   multicycle_control_ext #(.MEM_WAIT(1), .ALUOP_W(3), .STATE_W(5)) dut (
      .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
      .pc_write(pc_write), .branch(branch), .nef(nef), .iord(iord),
      .mem_req(mem_req), .mem_write(mem_write), .ir_write(ir_write),
      .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_zero(ext_zero),
      .pc_src(pc_src), .alu_op(alu_op), .illegal_op(illegal_op),
      .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   // Expected control word for a state, straight from the per-state output table.
   function automatic obs_t expect_of(input int st, input bit rdy, input bit rst, input bit ill);
      obs_t e;
      e = '0;
      e.state = st[4:0];
      case (st)
         0:  begin e.mem_req = 1; e.alu_src_b = 2'b01; e.pc_write = rdy; e.ir_write = rdy; end
         1:  e.alu_src_b = 2'b11;
         2:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
         3:  begin e.mem_req = 1; e.iord = 1; end
         4:  begin e.reg_write = 1; e.mem_to_reg = 2'b01; end
         5:  begin e.mem_req = 1; e.iord = 1; e.mem_write = rdy; end
         6:  begin e.alu_src_a = 1; e.alu_op = 3'b010; end
         7:  begin e.reg_write = 1; e.reg_dst = 2'b01; end
         8, 9: begin
            e.alu_src_a = 1; e.alu_op = 3'b001; e.branch = 1; e.pc_src = 2'b01;
            e.nef = (st == 9);
         end
         10: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_op = 3'b000; end
         11: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_op = 3'b011; e.ext_zero = 1; end
         12: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_op = 3'b100; e.ext_zero = 1; end
         13: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_op = 3'b101; end
         14: e.reg_write = 1;
         15: begin e.pc_write = 1; e.pc_src = 2'b10; end
         16: begin
            e.pc_write = 1; e.pc_src = 2'b10; e.reg_write = 1;
            e.reg_dst = 2'b10; e.mem_to_reg = 2'b10;
         end
         default: e = '0;
      endcase
      e.illegal_op = ill & rst;
      if (!rst) begin
         e.pc_write = 0; e.ir_write = 0; e.mem_write = 0; e.reg_write = 0; e.branch = 0;
      end
      return e;
   endfunction

   // The states an instruction walks through after DECODE; empty means unknown opcode.
   task automatic load_route(input logic [5:0] o, output bit known);
      path.delete();
      known = 1'b1;
      case (o)
         6'h00: begin path.push_back(6); path.push_back(7); end
         6'h23: begin path.push_back(2); path.push_back(3); path.push_back(4); end
         6'h2B: begin path.push_back(2); path.push_back(5); end
         6'h04: path.push_back(8);
         6'h05: path.push_back(9);
         6'h08: begin path.push_back(10); path.push_back(14); end
         6'h0C: begin path.push_back(11); path.push_back(14); end
         6'h0D: begin path.push_back(12); path.push_back(14); end
         6'h0A: begin path.push_back(13); path.push_back(14); end
         6'h02: path.push_back(15);
         6'h03: path.push_back(16);
         default: known = 1'b0;
      endcase
   endtask

   initial begin
      obs_t got, exp;
      bit   known;
      forever begin
         @(negedge clk);
         if (!reset) begin
            m_state = 0;
            m_ill   = 1'b0;
            path.delete();
         end
         got = '{pc_write, branch, nef, iord, mem_req, mem_write, ir_write, reg_write,
                 reg_dst, mem_to_reg, alu_src_a, alu_src_b, ext_zero, pc_src, alu_op,
                 illegal_op, state_dbg};
         exp = expect_of(m_state, mem_ready, reset, m_ill);
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL cycle_model t=%0t got=%h exp=%h", $time, got, exp);
         end
         if (reset) begin
            trace.push_back(got);
            m_ill = 1'b0;
            if (m_state == 0) begin
               if (mem_ready) m_state = 1;
            end else if (m_state == 1) begin
               load_route(op, known);
               m_ill = !known;
               m_state = (path.size() > 0) ? path.pop_front() : 0;
            end else if ((m_state == 3 || m_state == 5) && !mem_ready) begin
               m_state = m_state;
            end else begin
               m_state = (path.size() > 0) ? path.pop_front() : 0;
            end
         end
      end
   end

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
      end
   endtask

   task automatic chk_seq(input string nm, input int es[$]);
      chk({nm, "_len"}, trace.size(), es.size());
      foreach (es[i]) if (i < trace.size()) chk($sformatf("%s_st%0d", nm, i), int'(trace[i].state), es[i]);
   endtask

   // Drives one instruction; rdy[i] is mem_ready for cycle i.
   task automatic drive(input logic [5:0] o, input logic [15:0] rdy, input int n);
      trace.delete();
      for (int i = 0; i < n; i++) begin
         op = o;
         mem_ready = rdy[i];
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int es[$];
      #2;
      chk("rst_state", int'(state_dbg), 0);
      chk("rst_pc_write", int'(pc_write), 0);
      chk("rst_ir_write", int'(ir_write), 0);
      chk("rst_mem_req", int'(mem_req), 1);
      @(posedge clk);
      #1;
      reset = 1'b1;

      drive(6'h23, 16'h0084, 10);
      es = '{0, 0, 0, 1, 2, 3, 3, 3, 4, 0};
      chk_seq("lw", es);
      chk("lw_irw_c1", int'(trace[1].ir_write), 0);
      chk("lw_irw_c2", int'(trace[2].ir_write), 1);
      chk("lw_pcw_c2", int'(trace[2].pc_write), 1);
      chk("lw_wb_regw", int'(trace[8].reg_write), 1);
      chk("lw_wb_m2r", int'(trace[8].mem_to_reg), 1);

      drive(6'h2B, 16'h000F, 5);
      es = '{0, 1, 2, 5, 0};
      chk_seq("sw", es);
      chk("sw_memw", int'(trace[3].mem_write), 1);
      chk("sw_iord", int'(trace[3].iord), 1);

      drive(6'h05, 16'h0001, 4);
      es = '{0, 1, 9, 0};
      chk_seq("bne", es);
      chk("bne_branch", int'(trace[2].branch), 1);
      chk("bne_nef", int'(trace[2].nef), 1);
      chk("bne_aluop", int'(trace[2].alu_op), 1);
      chk("bne_pcsrc", int'(trace[2].pc_src), 1);

      drive(6'h04, 16'h0001, 4);
      es = '{0, 1, 8, 0};
      chk_seq("beq", es);
      chk("beq_nef", int'(trace[2].nef), 0);
      chk("beq_branch", int'(trace[2].branch), 1);

      drive(6'h0C, 16'h0001, 5);
      es = '{0, 1, 11, 14, 0};
      chk_seq("andi", es);
      chk("andi_ext", int'(trace[2].ext_zero), 1);
      chk("andi_aluop", int'(trace[2].alu_op), 3);
      chk("andi_wb_regw", int'(trace[3].reg_write), 1);
      chk("andi_wb_rdst", int'(trace[3].reg_dst), 0);

      drive(6'h0A, 16'h0001, 5);
      es = '{0, 1, 13, 14, 0};
      chk_seq("slti", es);
      chk("slti_ext", int'(trace[2].ext_zero), 0);
      chk("slti_aluop", int'(trace[2].alu_op), 5);

      drive(6'h03, 16'h0001, 4);
      es = '{0, 1, 16, 0};
      chk_seq("jal", es);
      chk("jal_pcw", int'(trace[2].pc_write), 1);
      chk("jal_regw", int'(trace[2].reg_write), 1);
      chk("jal_rdst", int'(trace[2].reg_dst), 2);
      chk("jal_m2r", int'(trace[2].mem_to_reg), 2);
      chk("jal_pcsrc", int'(trace[2].pc_src), 2);

      drive(6'h00, 16'h0001, 5);
      es = '{0, 1, 6, 7, 0};
      chk_seq("rtype", es);
      drive(6'h08, 16'h0001, 5);
      es = '{0, 1, 10, 14, 0};
      chk_seq("addi", es);
      drive(6'h0D, 16'h0001, 5);
      es = '{0, 1, 12, 14, 0};
      chk_seq("ori", es);
      drive(6'h02, 16'h0001, 4);
      es = '{0, 1, 15, 0};
      chk_seq("j", es);

      drive(6'h3F, 16'h0001, 4);
      es = '{0, 1, 0, 0};
      chk_seq("illegal", es);
      chk("ill_c1", int'(trace[1].illegal_op), 0);
      chk("ill_c2", int'(trace[2].illegal_op), 1);
      chk("ill_c3", int'(trace[3].illegal_op), 0);

      drive(6'h2B, 16'h0001, 3);
      op = 6'h2B;
      mem_ready = 1'b1;
      #1;
      chk("rstwr_pre_state", int'(state_dbg), 5);
      chk("rstwr_pre_memw", int'(mem_write), 1);
      reset = 1'b0;
      #1;
      chk("rstwr_memw", int'(mem_write), 0);
      chk("rstwr_state", int'(state_dbg), 0);
      chk("rstwr_pcw", int'(pc_write), 0);
      @(posedge clk);
      #2;
      reset = 1'b1;
      mem_ready = 1'b0;
      @(posedge clk);
      #1;
      drive(6'h2B, 16'h000F, 5);
      es = '{0, 1, 2, 5, 0};
      chk_seq("sw_after_rst", es);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
